// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver.
// Holds the FSM encoding, parity modes and the parity function.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Expected parity bit over the low nbits of d.
  function automatic logic parity_bit(
    input logic [8:0]  d,
    input int unsigned nbits,
    input int unsigned mode
  );
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < 9; i++)
      if (i < nbits) x = x ^ d[i];
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_if: serial line, tick and received-word bundle.
// master drives the line, slave is the receiver.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic                 tick;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 busy;

  modport master (
    output rx, tick,
    input  rx_data, rx_valid, parity_err,
    input  frame_err, break_det, busy
  );

  modport slave (
    input  rx, tick,
    output rx_data, rx_valid, parity_err,
    output frame_err, break_det, busy
  );
endinterface

// File: rtl/uart_rx_param_sync.sv
// uart_rx_sync: rx synchroniser plus tick-enabled sample history.
// o_maj is the 2-of-3 vote over the two stored samples and rx_s.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  input  logic i_tick,
  output logic o_rx_s,
  output logic o_maj
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_hist;
  logic                   w_rx_s;

  // Metastability chain; resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
  end

  // Older two samples; the third is the current rx_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_hist <= '1;
    else if (i_tick) r_hist <= {r_hist[0], w_rx_s};
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign o_rx_s = w_rx_s;
  assign o_maj  = (r_hist[1] & r_hist[0]) |
                  (r_hist[1] & w_rx_s)    |
                  (r_hist[0] & w_rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with parity/stop options.
// Reports parity, framing and break errors with each word.
import uart_pkg::*;

module uart_rx_param #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  state_t               r_state, w_state_nx;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic [IW-1:0]        r_idx, w_idx_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 r_stop, w_stop_nx;
  logic                 r_pbit, w_pbit_nx;
  logic                 r_perr_p, w_perr_p_nx;
  logic                 r_ferr_p, w_ferr_p_nx;
  logic [DATA_BITS-1:0] r_data, w_data_nx;
  logic                 r_valid, w_valid_nx;
  logic                 r_perr, w_perr_nx;
  logic                 r_ferr, w_ferr_nx;
  logic                 r_brk, w_brk_nx;
  logic                 w_fe;
  logic                 w_rx_s;
  logic                 w_maj;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (bus.rx),
    .i_tick (bus.tick),
    .o_rx_s (w_rx_s),
    .o_maj  (w_maj)
  );

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_stop   <= 1'b0;
      r_pbit   <= 1'b0;
      r_perr_p <= 1'b0;
      r_ferr_p <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_brk    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_idx    <= w_idx_nx;
      r_shift  <= w_shift_nx;
      r_stop   <= w_stop_nx;
      r_pbit   <= w_pbit_nx;
      r_perr_p <= w_perr_p_nx;
      r_ferr_p <= w_ferr_p_nx;
      r_data   <= w_data_nx;
      r_valid  <= w_valid_nx;
      r_perr   <= w_perr_nx;
      r_ferr   <= w_ferr_nx;
      r_brk    <= w_brk_nx;
    end
  end

  // Next-state and datapath; everything moves only on tick.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_idx_nx    = r_idx;
    w_shift_nx  = r_shift;
    w_stop_nx   = r_stop;
    w_pbit_nx   = r_pbit;
    w_perr_p_nx = r_perr_p;
    w_ferr_p_nx = r_ferr_p;
    w_data_nx   = r_data;
    w_valid_nx  = 1'b0;
    w_perr_nx   = r_perr;
    w_ferr_nx   = r_ferr;
    w_brk_nx    = r_brk;
    w_fe        = r_ferr_p | ~w_maj;
    if (bus.tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nx = S_START;
            w_cnt_nx   = '0;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            if (w_maj) begin
              w_state_nx = S_IDLE;
            end else begin
              w_state_nx  = S_DATA;
              w_cnt_nx    = '0;
              w_idx_nx    = '0;
              w_stop_nx   = 1'b0;
              w_pbit_nx   = 1'b0;
              w_perr_p_nx = 1'b0;
              w_ferr_p_nx = 1'b0;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            w_cnt_nx = '0;
            w_idx_nx = r_idx + 1'b1;
            if (DATA_BITS > 1)
              w_shift_nx = {w_maj, r_shift[DATA_BITS-1:1]};
            else
              w_shift_nx = w_maj;
            if (r_idx == I_LAST)
              w_state_nx = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_cnt == C_LAST) begin
            w_cnt_nx    = '0;
            w_pbit_nx   = w_maj;
            w_perr_p_nx = w_maj != parity_bit(9'(r_shift), DATA_BITS, PARITY);
            w_state_nx  = S_STOP;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            w_cnt_nx = '0;
            if (STOP_BITS == 2 && !r_stop) begin
              w_stop_nx   = 1'b1;
              w_ferr_p_nx = w_fe;
            end else begin
              w_valid_nx = 1'b1;
              w_data_nx  = r_shift;
              w_perr_nx  = r_perr_p;
              w_ferr_nx  = w_fe;
              w_brk_nx   = w_fe && (r_shift == '0) &&
                           (PARITY == PARITY_NONE || !r_pbit);
              w_state_nx = w_brk_nx ? S_BREAK_WAIT : S_IDLE;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        S_BREAK_WAIT: begin
          if (w_rx_s) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.break_det  = r_brk;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
